// File: rtl/data_memory_if.sv
// Memory-stage bus between the CPU and the data RAM: word address, write/read select,
// write data and registered read data.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] ADDR;
  logic                  WR_RD;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (
    output ADDR,
    output WR_RD,
    output din,
    input  dout
  );

  modport slave (
    input  ADDR,
    input  WR_RD,
    input  din,
    output dout
  );
endinterface

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM with write-first registered output.
// Per-word valid bits give a logical clear on reset without resetting the array.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  data_memory_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] rd_data;

  // Unreset storage; writes are dropped while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && bus.WR_RD) begin
      mem[bus.ADDR] <= bus.din;
    end
  end

  // Invalid words read as zero so stale contents never leak out after reset.
  always_comb begin
    rd_data = '0;
    if (valid_q[bus.ADDR]) begin
      rd_data = mem[bus.ADDR];
    end
  end

  always_comb begin
    dout_d = rd_data;
    if (bus.WR_RD) begin
      dout_d = bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dout_q  <= '0;
    end else begin
      if (bus.WR_RD) begin
        valid_q[bus.ADDR] <= 1'b1;
      end
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset clear, write-first readback, overwrite,
// asynchronous reset mid-operation, writes during reset and read hold/latency.
module tb_data_memory;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers only: present one access, take the edge, settle 1 time unit past it.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ADDR  = a;
    bus.WR_RD = 1'b1;
    bus.din   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bus.ADDR  = a;
    bus.WR_RD = 1'b0;
    bus.din   = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b1;
    bus.ADDR  = '0;
    bus.WR_RD = 1'b0;
    bus.din   = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL reset_async dout=%h expected=%h", bus.dout, 32'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int k = 0; k < 2; k++) begin
        do_read(a[AW-1:0]);
        checks++;
        if (bus.dout !== 32'h0) begin
          failures++;
          $display("FAIL reset_read addr=%0d dout=%h expected=%h", a, bus.dout, 32'h0);
        end
      end
    end
  endtask

  task automatic test_write_readback;
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] vals  [3];
    addrs[0] = 10'd0;    vals[0] = 32'hDEADBEEF;
    addrs[1] = 10'd1;    vals[1] = 32'h12345678;
    addrs[2] = 10'd1023; vals[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      do_write(addrs[i], vals[i]);
      checks++;
      if (bus.dout !== vals[i]) begin
        failures++;
        $display("FAIL write_through addr=%0d dout=%h expected=%h", addrs[i], bus.dout, vals[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i]);
      checks++;
      if (bus.dout !== vals[i]) begin
        failures++;
        $display("FAIL readback addr=%0d dout=%h expected=%h", addrs[i], bus.dout, vals[i]);
      end
    end
  endtask

  task automatic test_overwrite;
    do_write(10'd5, 32'hA5A5A5A5);
    do_write(10'd5, 32'h5A5A5A5A);
    checks++;
    if (bus.dout !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL overwrite_through dout=%h expected=%h", bus.dout, 32'h5A5A5A5A);
    end
    do_read(10'd5);
    checks++;
    if (bus.dout !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL overwrite_read dout=%h expected=%h", bus.dout, 32'h5A5A5A5A);
    end
    do_read(10'd4);
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL neighbour_4 dout=%h expected=%h", bus.dout, 32'h0);
    end
    do_read(10'd6);
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL neighbour_6 dout=%h expected=%h", bus.dout, 32'h0);
    end
  endtask

  task automatic test_mid_reset;
    do_write(10'd7, 32'hCAFEF00D);
    do_read(10'd7);
    checks++;
    if (bus.dout !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL pre_reset_read dout=%h expected=%h", bus.dout, 32'hCAFEF00D);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL async_clear dout=%h expected=%h", bus.dout, 32'h0);
    end
    #1;
    rst_n = 1'b1;
    do_read(10'd7);
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_read7 dout=%h expected=%h", bus.dout, 32'h0);
    end
    do_read(10'd0);
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL post_reset_read0 dout=%h expected=%h", bus.dout, 32'h0);
    end
  endtask

  task automatic test_write_in_reset;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_write(10'd9, 32'h11111111);
      checks++;
      if (bus.dout !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold edge=%0d dout=%h expected=%h", k, bus.dout, 32'h0);
      end
    end
    rst_n = 1'b1;
    do_read(10'd9);
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL write_ignored dout=%h expected=%h", bus.dout, 32'h0);
    end
  endtask

  task automatic test_hold_latency;
    do_write(10'd2, 32'h00000042);
    checks++;
    if (bus.dout !== 32'h00000042) begin
      failures++;
      $display("FAIL hold_write dout=%h expected=%h", bus.dout, 32'h00000042);
    end
    do_read(10'd2);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.dout !== 32'h00000042) begin
        failures++;
        $display("FAIL hold_cycle=%0d dout=%h expected=%h", k, bus.dout, 32'h00000042);
      end
    end
    bus.ADDR = 10'd3;
    #3;
    checks++;
    if (bus.dout !== 32'h00000042) begin
      failures++;
      $display("FAIL latency_before_edge dout=%h expected=%h", bus.dout, 32'h00000042);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.dout !== 32'h0) begin
      failures++;
      $display("FAIL latency_after_edge dout=%h expected=%h", bus.dout, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    do_write(10'd100, 32'h00000001);
    do_write(10'd101, 32'h00000002);
    do_read(10'd100);
    checks++;
    if (bus.dout !== 32'h00000001) begin
      failures++;
      $display("FAIL b2b_read100 dout=%h expected=%h", bus.dout, 32'h00000001);
    end
    do_write(10'd100, 32'h00000003);
    do_read(10'd100);
    checks++;
    if (bus.dout !== 32'h00000003) begin
      failures++;
      $display("FAIL b2b_read100_new dout=%h expected=%h", bus.dout, 32'h00000003);
    end
    do_read(10'd101);
    checks++;
    if (bus.dout !== 32'h00000002) begin
      failures++;
      $display("FAIL b2b_read101 dout=%h expected=%h", bus.dout, 32'h00000002);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_readback();
    test_overwrite();
    test_mid_reset();
    test_write_in_reset();
    test_hold_latency();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
